live_value_table: RTL and testbench

LIVE_VALUE_TABLE -- requirements
Module: live_value_table

---
 rtl/live_value_table_if.sv | 28 ++
 rtl/live_value_table.sv | 135 +++++++++++++
 tb/tb_live_value_table.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/live_value_table_if.sv
// live_value_table_if: access bus of the live value table.
// master drives flush, write strobes/addresses and read strobes/addresses;
// slave returns the per-reader last-writer index, its qualifier, ready and
// the write-collision pulse.
interface live_value_table_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = (NB_WRAGENT == 1 ? 1 : $clog2(NB_WRAGENT))
);
  logic                               flush;
  logic [NB_WRAGENT-1:0]              wren;
  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr;
  logic [NB_RDAGENT-1:0]              rden;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect;
  logic [NB_RDAGENT-1:0]              rdvalid;
  logic                               ready;
  logic                               wrcollision;
  modport master (
    output flush, wren, wraddr, rden, rdaddr,
    input  rdselect, rdvalid, ready, wrcollision
  );
  modport slave (
    input  flush, wren, wraddr, rden, rdaddr,
    output rdselect, rdvalid, ready, wrcollision
  );
endinterface

// File: rtl/live_value_table.sv
// live_value_table: tracks, per row, which write agent wrote it last.
// Ports: aclk (rising edge), areset (async, active high), bus (slave modport):
//   flush -> re-run the clearing sweep; wren/wraddr -> per-agent writes;
//   rden/rdaddr -> per-agent reads; rdselect/rdvalid -> read results after
//   RD_LATENCY cycles; ready -> table initialised; wrcollision -> one-cycle
//   pulse after two agents wrote the same row.
module live_value_table #(
  parameter int ADDR_WIDTH   = 8,
  parameter int RAM_DEPTH    = 2**ADDR_WIDTH,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = (NB_WRAGENT == 1 ? 1 : $clog2(NB_WRAGENT)),
  parameter int RD_LATENCY   = 1,
  parameter int WRITE_FIRST  = 1
) (
  input logic aclk,
  input logic areset,
  live_value_table_if.slave bus
);
  localparam int IW = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH-1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                             state;
  logic [ADDR_WIDTH-1:0]              cnt;
  logic                               ready;
  logic                               wrcollision;
  logic [NB_RDAGENT-1:0]              rdvalid;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect;
  logic [SELECT_WIDTH-1:0]            mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0]              waddr [NB_WRAGENT];
  logic [ADDR_WIDTH-1:0]              raddr [NB_RDAGENT];
  logic [NB_WRAGENT-1:0]              wr_ok;
  logic                               coll;
  logic [NB_RDAGENT-1:0]              rd_ok;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] rd_val;
  logic [NB_RDAGENT-1:0]              fv;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] fs;

  for (genvar i = 0; i < NB_WRAGENT; i++) begin : g_wa
    assign waddr[i] = bus.wraddr[ADDR_WIDTH*i +: ADDR_WIDTH];
  end
  for (genvar j = 0; j < NB_RDAGENT; j++) begin : g_ra
    assign raddr[j] = bus.rdaddr[ADDR_WIDTH*j +: ADDR_WIDTH];
  end

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH;
  endfunction

  // Out-of-range rows read as 0; with WRITE_FIRST the highest accepted
  // same-cycle writer of the row overrides the stored entry.
  function automatic logic [SELECT_WIDTH-1:0] lookup(input logic [ADDR_WIDTH-1:0] a);
    logic [SELECT_WIDTH-1:0] s;
    s = in_range(a) ? mem[IW'(a)] : '0;
    for (int i = 0; i < NB_WRAGENT; i++)
      if (WRITE_FIRST != 0 && wr_ok[i] && waddr[i] == a) s = SELECT_WIDTH'(i);
    return s;
  endfunction

  always_comb begin
    wr_ok = '0;
    coll = 1'b0;
    for (int i = 0; i < NB_WRAGENT; i++) begin
      wr_ok[i] = ready && bus.wren[i] && in_range(waddr[i]);
      for (int k = 0; k < i; k++)
        if (wr_ok[i] && wr_ok[k] && waddr[i] == waddr[k]) coll = 1'b1;
    end
  end

  // ready is still high in the cycle flush is sampled, so those reads complete.
  assign rd_ok = ready ? bus.rden : '0;

  always_comb begin
    rd_val = '0;
    for (int j = 0; j < NB_RDAGENT; j++)
      rd_val[j*SELECT_WIDTH +: SELECT_WIDTH] = lookup(raddr[j]);
  end

  if (RD_LATENCY == 2) begin : g_pipe
    always_ff @(posedge aclk or posedge areset)
      if (areset) begin
        fv <= '0;
        fs <= '0;
      end else begin
        fv <= rd_ok;
        fs <= rd_val;
      end
  end else begin : g_direct
    assign fv = rd_ok;
    assign fs = rd_val;
  end

  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state       <= INIT;
      cnt         <= '0;
      ready       <= 1'b0;
      wrcollision <= 1'b0;
      rdvalid     <= '0;
      rdselect    <= '0;
    end else begin
      wrcollision <= coll;
      rdvalid     <= fv;
      for (int j = 0; j < NB_RDAGENT; j++)
        if (fv[j]) rdselect[j*SELECT_WIDTH +: SELECT_WIDTH] <= fs[j*SELECT_WIDTH +: SELECT_WIDTH];
      if (bus.flush) begin
        state <= INIT;
        cnt   <= '0;
        ready <= 1'b0;
      end else if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state <= RUN;
          ready <= 1'b1;
        end
      end
    end

  // Table storage has no reset; only the INIT sweep clears it.
  always_ff @(posedge aclk)
    if (state == INIT) begin
      if (!areset) mem[IW'(cnt)] <= '0;
    end else begin
      for (int i = 0; i < NB_WRAGENT; i++)
        if (wr_ok[i]) mem[IW'(waddr[i])] <= SELECT_WIDTH'(i);
    end

  assign bus.ready       = ready;
  assign bus.wrcollision = wrcollision;
  assign bus.rdvalid     = rdvalid;
  assign bus.rdselect    = rdselect;
endmodule

// File: tb/tb_live_value_table.sv
// tb_live_value_table: directed vectors against two table instances
// (A: RD_LATENCY=1, WRITE_FIRST=1; B: RD_LATENCY=2, WRITE_FIRST=0).
module tb_live_value_table;
  localparam int AW = 5, DEPTH = 16, NW = 4, NR = 2, SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  live_value_table_if #(.ADDR_WIDTH(AW), .NB_WRAGENT(NW), .NB_RDAGENT(NR), .SELECT_WIDTH(SW)) ia ();
  live_value_table_if #(.ADDR_WIDTH(AW), .NB_WRAGENT(NW), .NB_RDAGENT(NR), .SELECT_WIDTH(SW)) ib ();

  live_value_table #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NB_WRAGENT(NW), .NB_RDAGENT(NR),
    .SELECT_WIDTH(SW), .RD_LATENCY(1), .WRITE_FIRST(1)) dut_a (.aclk(clk), .areset(rst), .bus(ia.slave));
  live_value_table #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NB_WRAGENT(NW), .NB_RDAGENT(NR),
    .SELECT_WIDTH(SW), .RD_LATENCY(2), .WRITE_FIRST(0)) dut_b (.aclk(clk), .areset(rst), .bus(ib.slave));

  assign ib.flush  = ia.flush;
  assign ib.wren   = ia.wren;
  assign ib.wraddr = ia.wraddr;
  assign ib.rden   = ia.rden;
  assign ib.rdaddr = ia.rdaddr;

  typedef struct packed {
    logic [NW-1:0]          wr;
    logic [NW-1:0][AW-1:0]  wa;
    logic [NR-1:0]          rd;
    logic [NR-1:0][AW-1:0]  ra;
    logic [NR-1:0][SW-1:0]  ea;
    logic [NR-1:0][SW-1:0]  eb;
    logic                   coll;
  } vec_t;

  vec_t q[$];
  int checks = 0;
  int errors = 0;
  int n;

  function automatic vec_t mk(input logic [NW-1:0] wr, input logic [NW*AW-1:0] wa,
                              input logic [NR-1:0] rd, input logic [NR*AW-1:0] ra,
                              input logic [NR*SW-1:0] ea, input logic [NR*SW-1:0] eb,
                              input logic coll);
    vec_t v;
    v.wr = wr; v.wa = wa; v.rd = rd; v.ra = ra; v.ea = ea; v.eb = eb; v.coll = coll;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic fl);
    ia.flush  = fl;
    ia.wren   = v.wr;
    ia.wraddr = v.wa;
    ia.rden   = v.rd;
    ia.rdaddr = v.ra;
  endtask

  task automatic idle();
    drive('0, 1'b0);
  endtask

  task automatic run_q();
    for (int k = 0; k <= q.size(); k++) begin
      if (k < q.size()) drive(q[k], 1'b0); else idle();
      step();
      if (k < q.size()) begin
        chk($sformatf("v%0d_rdvalid_a", k), ia.rdvalid, q[k].rd);
        chk($sformatf("v%0d_rdselect_a", k), ia.rdselect, q[k].ea);
        chk($sformatf("v%0d_coll_a", k), ia.wrcollision, q[k].coll);
        chk($sformatf("v%0d_coll_b", k), ib.wrcollision, q[k].coll);
      end
      if (k > 0) begin
        chk($sformatf("v%0d_rdvalid_b", k-1), ib.rdvalid, q[k-1].rd);
        chk($sformatf("v%0d_rdselect_b", k-1), ib.rdselect, q[k-1].eb);
      end
    end
    q.delete();
  endtask

  task automatic read_all();
    for (int r = 0; r < DEPTH; r++)
      q.push_back(mk('0, '0, 2'b11, {5'(15 - r), 5'(r)}, '0, '0, 1'b0));
    q.push_back(mk('0, '0, 2'b11, {5'd31, 5'd16}, '0, '0, 1'b0));
    run_q();
  endtask

  // Counts samples with ready=0 while hammering writes and reads that must be ignored.
  task automatic count_init(input int fl_at, output int cnt);
    cnt = 0;
    while (!ia.ready && cnt < 100) begin
      cnt++;
      ia.flush  = (cnt == fl_at);
      ia.wren   = 4'b1100;
      ia.wraddr = {5'd0, 5'd1, 10'd0};
      ia.rden   = 2'b11;
      ia.rdaddr = {5'd0, 5'd1};
      step();
      chk("init_rdvalid_a", ia.rdvalid, 0);
      chk("init_rdvalid_b", ib.rdvalid, 0);
    end
    idle();
    chk("ready_b_after_init", ib.ready, 1);
  endtask

  initial begin
    idle();
    repeat (3) step();
    chk("rst_ready_a", ia.ready, 0);
    chk("rst_rdvalid_a", ia.rdvalid, 0);
    chk("rst_rdselect_a", ia.rdselect, 0);
    chk("rst_coll_a", ia.wrcollision, 0);
    chk("rst_rdvalid_b", ib.rdvalid, 0);
    chk("rst_rdselect_b", ib.rdselect, 0);
    rst = 1'b0;
    count_init(0, n);
    chk("sweep_len_after_reset", n, 16);
    read_all();

    q.push_back(mk(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0},  2'b00, '0,            {2'd0, 2'd0}, {2'd0, 2'd0}, 1'b0));
    q.push_back(mk(4'b0000, '0,                        2'b10, {5'd5, 5'd0},  {2'd2, 2'd0}, {2'd2, 2'd0}, 1'b0));
    q.push_back(mk(4'b1001, {5'd7, 5'd0, 5'd0, 5'd7},  2'b01, {5'd0, 5'd7},  {2'd2, 2'd3}, {2'd2, 2'd0}, 1'b1));
    q.push_back(mk(4'b0000, '0,                        2'b01, {5'd0, 5'd7},  {2'd2, 2'd3}, {2'd2, 2'd3}, 1'b0));
    q.push_back(mk(4'b0100, {5'd0, 5'd4, 5'd0, 5'd0},  2'b00, '0,            {2'd2, 2'd3}, {2'd2, 2'd3}, 1'b0));
    q.push_back(mk(4'b0010, {5'd0, 5'd0, 5'd4, 5'd0},  2'b01, {5'd0, 5'd4},  {2'd2, 2'd1}, {2'd2, 2'd2}, 1'b0));
    q.push_back(mk(4'b0000, '0,                        2'b11, {5'd4, 5'd4},  {2'd1, 2'd1}, {2'd1, 2'd1}, 1'b0));
    q.push_back(mk(4'b1111, {5'd20, 5'd3, 5'd2, 5'd1}, 2'b11, {5'd3, 5'd20}, {2'd2, 2'd0}, {2'd0, 2'd0}, 1'b0));
    q.push_back(mk(4'b0000, '0,                        2'b11, {5'd2, 5'd1},  {2'd1, 2'd0}, {2'd1, 2'd0}, 1'b0));
    q.push_back(mk(4'b1110, {5'd1, 5'd1, 5'd1, 5'd0},  2'b11, {5'd1, 5'd3},  {2'd3, 2'd2}, {2'd0, 2'd2}, 1'b1));
    q.push_back(mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd9},  2'b10, {5'd1, 5'd0},  {2'd3, 2'd2}, {2'd3, 2'd2}, 1'b0));
    q.push_back(mk(4'b1000, {5'd31, 5'd0, 5'd0, 5'd0}, 2'b11, {5'd7, 5'd31}, {2'd3, 2'd0}, {2'd3, 2'd0}, 1'b0));
    q.push_back(mk(4'b0000, '0,                        2'b11, {5'd9, 5'd9},  {2'd0, 2'd0}, {2'd0, 2'd0}, 1'b0));
    run_q();

    drive(mk('0, '0, 2'b11, {5'd5, 5'd7}, '0, '0, 1'b0), 1'b1);
    step();
    chk("flush_read_rdvalid_a", ia.rdvalid, 2'b11);
    chk("flush_read_rdselect_a", ia.rdselect, {2'd2, 2'd3});
    chk("flush_ready_a", ia.ready, 0);
    idle();
    step();
    chk("flush_read_rdvalid_b", ib.rdvalid, 2'b11);
    chk("flush_read_rdselect_b", ib.rdselect, {2'd2, 2'd3});
    chk("flush_next_rdvalid_a", ia.rdvalid, 0);
    count_init(3, n);
    chk("sweep_len_flush_restart", n, 19);
    read_all();

    drive(mk(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, '0, '0, '0, '0, 1'b0), 1'b0);
    step();
    drive(mk('0, '0, 2'b11, {5'd5, 5'd5}, '0, '0, 1'b0), 1'b0);
    step();
    chk("pre_rst_rdselect_a", ia.rdselect, {2'd2, 2'd2});
    #2 rst = 1'b1;
    #1;
    chk("midread_rst_rdvalid_a", ia.rdvalid, 0);
    chk("midread_rst_rdselect_a", ia.rdselect, 0);
    chk("midread_rst_ready_a", ia.ready, 0);
    chk("midread_rst_rdvalid_b", ib.rdvalid, 0);
    idle();
    step();
    chk("midread_rst_pipe_b", ib.rdvalid, 0);
    rst = 1'b0;
    count_init(0, n);
    chk("sweep_len_after_midread_rst", n, 16);

    drive(mk(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, '0, '0, '0, '0, 1'b0), 1'b0);
    step();
    drive(mk('0, '0, 2'b01, {5'd0, 5'd5}, '0, '0, 1'b0), 1'b1);
    step();
    chk("flush2_rdselect_a", ia.rdselect, {2'd0, 2'd2});
    idle();
    repeat (9) step();
    chk("row9_hold_rdselect_a", ia.rdselect, {2'd0, 2'd2});
    rst = 1'b1;
    #1;
    chk("row9_rst_rdselect_a", ia.rdselect, 0);
    chk("row9_rst_ready_a", ia.ready, 0);
    chk("row9_rst_rdselect_b", ib.rdselect, 0);
    step();
    rst = 1'b0;
    count_init(0, n);
    chk("sweep_len_after_row9_rst", n, 16);
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
